// File: rtl/bist_march_ctrl.sv
// March C- memory BIST sequencer: drives an external up/down address generator and a
// single-port memory, checks read data and records the first failing address/element.
module bist_march_ctrl #(
    parameter int Adr_size  = 4,
    parameter int Data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 c_out,
    input  logic [Adr_size-1:0]  adres,
    output logic                 adr_en,
    output logic                 adr_up_down,
    output logic                 adr_pr_rst,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic [Data_size-1:0] mem_wdata,
    input  logic [Data_size-1:0] mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [Adr_size-1:0]  fail_adr,
    output logic [2:0]           fail_elem
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESET = 3'd1,
        ST_READ   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Elements M3/M4 walk downward, all others upward.
    function automatic logic elem_dir(input logic [2:0] e);
        case (e)
            3'd3, 3'd4: elem_dir = 1'b0;
            default:    elem_dir = 1'b1;
        endcase
    endfunction

    // Value each element expects to read back (r1 in M2/M4, r0 elsewhere).
    function automatic logic rd_bit(input logic [2:0] e);
        case (e)
            3'd2, 3'd4: rd_bit = 1'b1;
            default:    rd_bit = 1'b0;
        endcase
    endfunction

    // Value each element writes (w1 in M1/M3, w0 elsewhere).
    function automatic logic wr_bit(input logic [2:0] e);
        case (e)
            3'd1, 3'd3: wr_bit = 1'b1;
            default:    wr_bit = 1'b0;
        endcase
    endfunction

    state_t                state_r, next_state_s;
    logic [2:0]            elem_r, elem_next_s;
    logic                  adr_en_s, clr_fail_s, mismatch_s;
    logic [Data_size-1:0]  exp_rd_s;
    logic                  adr_up_down_r, adr_pr_rst_r, mem_re_r, mem_we_r;
    logic [Data_size-1:0]  mem_wdata_r;
    logic                  busy_r, done_r, fail_r;
    logic [Adr_size-1:0]   fail_adr_r;
    logic [2:0]            fail_elem_r;

    // Next-state, element sequencing, address step and read comparison.
    always_comb begin
        next_state_s = state_r;
        elem_next_s  = elem_r;
        adr_en_s     = 1'b0;
        clr_fail_s   = 1'b0;
        mismatch_s   = 1'b0;
        exp_rd_s     = rd_bit(elem_r) ? {Data_size{1'b1}} : {Data_size{1'b0}};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state_s = ST_PRESET;
                    elem_next_s  = 3'd0;
                    clr_fail_s   = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_PRESET: begin
                if (elem_r == 3'd0) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            ST_READ: next_state_s = ST_CHECK;
            ST_CHECK: begin
                mismatch_s = (mem_rdata != exp_rd_s);
                // M5 is read-only, so its check is the last op of the address.
                if (elem_r != 3'd5) begin
                    next_state_s = ST_WRITE;
                end else if (c_out) begin
                    next_state_s = ST_DONE;
                end else begin
                    adr_en_s     = 1'b1;
                    next_state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (!c_out) begin
                    adr_en_s     = 1'b1;
                    next_state_s = (elem_r == 3'd0) ? ST_WRITE : ST_READ;
                end else if (elem_r < 3'd5) begin
                    elem_next_s  = elem_r + 3'd1;
                    next_state_s = ST_PRESET;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and element registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            elem_r  <= 3'd0;
        end else begin
            state_r <= next_state_s;
            elem_r  <= elem_next_s;
        end
    end

    // Strobes and status decoded from the upcoming state so they leave on flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_up_down_r <= 1'b1;
            adr_pr_rst_r  <= 1'b0;
            mem_re_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_wdata_r   <= {Data_size{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            adr_up_down_r <= elem_dir(elem_next_s);
            adr_pr_rst_r  <= (next_state_s == ST_PRESET);
            mem_re_r      <= (next_state_s == ST_READ);
            mem_we_r      <= (next_state_s == ST_WRITE);
            mem_wdata_r   <= ((next_state_s == ST_WRITE) && wr_bit(elem_next_s)) ?
                             {Data_size{1'b1}} : {Data_size{1'b0}};
            busy_r        <= next_state_s inside {ST_PRESET, ST_READ, ST_CHECK, ST_WRITE};
            done_r        <= (next_state_s == ST_DONE);
        end
    end

    // Sticky fail flag; only the first mismatch of a run is recorded.
    always_ff @(posedge clk) begin
        if (rst || clr_fail_s) begin
            fail_r      <= 1'b0;
            fail_adr_r  <= {Adr_size{1'b0}};
            fail_elem_r <= 3'd0;
        end else if (mismatch_s) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
                fail_adr_r  <= adres;
                fail_elem_r <= elem_r;
            end
        end
    end

    assign adr_en      = adr_en_s;
    assign adr_up_down = adr_up_down_r;
    assign adr_pr_rst  = adr_pr_rst_r;
    assign mem_re      = mem_re_r;
    assign mem_we      = mem_we_r;
    assign mem_wdata   = mem_wdata_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fail        = fail_r;
    assign fail_adr    = fail_adr_r;
    assign fail_elem   = fail_elem_r;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: address counter + 16x8 memory with injectable faults,
// per-run expectations queued at start and retired when done rises.
module tb_bist_march_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int N   = 16;
    localparam int LAT = 246;

    typedef struct {
        logic          fail;
        logic [AW-1:0] adr;
        logic [2:0]    elem;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start;
    logic          c_out;
    logic [AW-1:0] adres = '0;
    logic          adr_en, adr_up_down, adr_pr_rst, mem_re, mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, done, fail;
    logic [AW-1:0] fail_adr;
    logic [2:0]    fail_elem;

    logic [DW-1:0] mem    [N];
    logic [DW-1:0] stuck1 [N];
    int            flip_elem [N];
    int            cyc = 0;
    int            pr_cnt = 0, dir_err = 0, viol = 0, wd_err = 0;
    int            mon_e;
    logic          exp_dir;
    logic [DW-1:0] exp_wd;
    int            n_checks = 0, n_fail = 0;
    exp_t          sb_q[$];

    bist_march_ctrl #(.Adr_size(AW), .Data_size(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .c_out(c_out), .adres(adres),
        .adr_en(adr_en), .adr_up_down(adr_up_down), .adr_pr_rst(adr_pr_rst),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_adr(fail_adr), .fail_elem(fail_elem)
    );

    // Clock
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Address generator model: preset, then count in the commanded direction.
    always @(posedge clk) begin
        if (adr_pr_rst) adres <= adr_up_down ? {AW{1'b0}} : {AW{1'b1}};
        else if (adr_en) adres <= adr_up_down ? adres + 4'd1 : adres - 4'd1;
    end
    assign c_out = adr_up_down ? (adres == {AW{1'b1}}) : (adres == {AW{1'b0}});

    // Memory model with stuck-at-1 bits and element-specific read corruption.
    always @(posedge clk) begin
        if (mem_we) mem[adres] <= mem_wdata | stuck1[adres];
        if (mem_re) mem_rdata <= (mem[adres] | stuck1[adres]) ^
                                 ((flip_elem[adres] == pr_cnt - 1) ? 8'h01 : 8'h00);
    end

    // Element the DUT should be working on, and its direction / write value.
    always_comb begin
        mon_e   = adr_pr_rst ? pr_cnt : pr_cnt - 1;
        exp_dir = (mon_e == 3 || mon_e == 4) ? 1'b0 : 1'b1;
        exp_wd  = (mon_e == 1 || mon_e == 3) ? 8'hFF : 8'h00;
    end

    // Run monitor: preset pulses, direction, write data and strobe exclusivity.
    always @(negedge clk) begin
        if (start && !busy && !rst) begin
            pr_cnt <= 0; dir_err <= 0; viol <= 0; wd_err <= 0;
        end else begin
            if (adr_pr_rst) pr_cnt <= pr_cnt + 1;
            if (busy && adr_up_down !== exp_dir) dir_err <= dir_err + 1;
            if (mem_we && mem_wdata !== exp_wd) wd_err <= wd_err + 1;
            if ((!busy && (adr_en | adr_pr_rst | mem_re | mem_we)) ||
                (int'(mem_re) + int'(mem_we) + int'(adr_pr_rst) > 1) ||
                (adr_en && (mem_re || adr_pr_rst)))
                viol <= viol + 1;
        end
    end

    // Pulse start, optionally poke start again mid-run, measure PRESET-to-DONE cycles.
    task automatic do_run(input int poke_elem, output int lat, output logic f0, output logic d0);
        int  t0 = -1;
        bit  poked = 0, clr = 0;
        lat = -1; f0 = 1'bx; d0 = 1'bx;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (clr) begin #1 start = 1'b0; clr = 0; end
            if (adr_pr_rst && t0 < 0) begin t0 = cyc; f0 = fail; d0 = done; end
            if (done) begin lat = (t0 < 0) ? -2 : cyc - t0; break; end
            if (poke_elem >= 0 && !poked && pr_cnt == poke_elem + 1 && !adr_pr_rst) begin
                #1 start = 1'b1; poked = 1; clr = 1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail got %b exp 0", fail); end
        n_checks++; if (adr_up_down !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b exp 1", adr_up_down); end
        n_checks++; if ({adr_en, adr_pr_rst, mem_re, mem_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes got %b exp 0000", {adr_en, adr_pr_rst, mem_re, mem_we}); end
        n_checks++; if ({mem_wdata, fail_adr, fail_elem} !== 15'd0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_wdata, fail_adr, fail_elem); end
    endtask

    task automatic test_fault_free;
        exp_t e, g; int lat, nz; logic f0, d0;
        e.fail = 1'b0; e.adr = '0; e.elem = 3'd0; e.lat = LAT; sb_q.push_back(e);
        do_run(-1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL ff_latency got %0d exp %0d", lat, g.lat); end
        n_checks++; if ({fail, fail_adr, fail_elem} !== {g.fail, g.adr, g.elem}) begin
            n_fail++; $display("FAIL ff_result got %b/%0d/%0d exp %b/%0d/%0d", fail, fail_adr, fail_elem, g.fail, g.adr, g.elem); end
        nz = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 8'h00) nz++;
        n_checks++; if (nz != 0) begin n_fail++; $display("FAIL ff_cells got %0d nonzero exp 0", nz); end
        n_checks++; if (pr_cnt != 6) begin n_fail++; $display("FAIL ff_presets got %0d exp 6", pr_cnt); end
        n_checks++; if (dir_err != 0) begin n_fail++; $display("FAIL ff_direction got %0d errs exp 0", dir_err); end
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL ff_strobes got %0d errs exp 0", viol); end
        n_checks++; if (wd_err != 0) begin n_fail++; $display("FAIL ff_wdata got %0d errs exp 0", wd_err); end
        repeat (3) @(negedge clk);
        n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL ff_done_held got %b exp 10", {done, busy}); end
    endtask

    task automatic test_stuck_at;
        exp_t e, g; int lat; logic f0, d0;
        stuck1[5] = 8'h01;
        e.fail = 1'b1; e.adr = 4'd5; e.elem = 3'd1; e.lat = LAT; sb_q.push_back(e);
        do_run(-1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL sa_latency got %0d exp %0d", lat, g.lat); end
        n_checks++; if ({fail, fail_adr, fail_elem} !== {g.fail, g.adr, g.elem}) begin
            n_fail++; $display("FAIL sa_result got %b/%0d/%0d exp %b/%0d/%0d", fail, fail_adr, fail_elem, g.fail, g.adr, g.elem); end
        stuck1[5] = 8'h00;
    endtask

    task automatic test_restart_clears;
        exp_t e, g; int lat; logic f0, d0;
        e.fail = 1'b0; e.adr = '0; e.elem = 3'd0; e.lat = LAT; sb_q.push_back(e);
        do_run(-1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if ({f0, d0} !== 2'b00) begin n_fail++; $display("FAIL rs_cleared got fail/done %b%b exp 00", f0, d0); end
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL rs_latency got %0d exp %0d", lat, g.lat); end
        n_checks++; if (fail !== g.fail) begin n_fail++; $display("FAIL rs_fail got %b exp %b", fail, g.fail); end
    endtask

    task automatic test_two_faults;
        exp_t e, g; int lat; logic f0, d0;
        flip_elem[3] = 1; flip_elem[9] = 4;
        e.fail = 1'b1; e.adr = 4'd3; e.elem = 3'd1; e.lat = LAT; sb_q.push_back(e);
        do_run(-1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if ({fail, fail_adr, fail_elem} !== {g.fail, g.adr, g.elem}) begin
            n_fail++; $display("FAIL tf_result got %b/%0d/%0d exp %b/%0d/%0d", fail, fail_adr, fail_elem, g.fail, g.adr, g.elem); end
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL tf_latency got %0d exp %0d", lat, g.lat); end
        flip_elem[3] = -1; flip_elem[9] = -1;
    endtask

    task automatic test_mid_reset;
        exp_t e, g; int lat, strobes; bit reached = 0; logic f0, d0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pr_cnt == 3 && !adr_pr_rst) begin reached = 1; break; end
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL mr_reach_m2 got timeout exp element 2"); end
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, done, fail} !== 3'b000) begin n_fail++; $display("FAIL mr_idle got %b exp 000", {busy, done, fail}); end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            if (adr_en | adr_pr_rst | mem_re | mem_we) strobes++;
            @(negedge clk);
        end
        n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL mr_quiet got %0d strobes exp 0", strobes); end
        e.fail = 1'b0; e.adr = '0; e.elem = 3'd0; e.lat = LAT; sb_q.push_back(e);
        do_run(-1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL mr_latency got %0d exp %0d", lat, g.lat); end
        n_checks++; if ({fail, pr_cnt == 6, viol == 0} !== {g.fail, 2'b11}) begin
            n_fail++; $display("FAIL mr_rerun got fail=%b presets=%0d viol=%0d exp 0/6/0", fail, pr_cnt, viol); end
    endtask

    task automatic test_start_ignored;
        exp_t e, g; int lat; logic f0, d0;
        e.fail = 1'b0; e.adr = '0; e.elem = 3'd0; e.lat = LAT; sb_q.push_back(e);
        do_run(1, lat, f0, d0);
        g = sb_q.pop_front();
        n_checks++; if (lat != g.lat) begin n_fail++; $display("FAIL si_latency got %0d exp %0d", lat, g.lat); end
        n_checks++; if (pr_cnt != 6) begin n_fail++; $display("FAIL si_presets got %0d exp 6", pr_cnt); end
        n_checks++; if (fail !== g.fail) begin n_fail++; $display("FAIL si_fail got %b exp %b", fail, g.fail); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < N; i++) begin stuck1[i] = 8'h00; flip_elem[i] = -1; end
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_restart_clears();
        test_two_faults();
        test_mid_reset();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_march_ctrl.md
BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

Interface
REQ-001 Param Adr_size, default 4: address width; matches the BIST address generator.
REQ-002 Param Data_size, default 8: memory data width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  run request; sampled only in IDLE or DONE.
REQ-006 c_out  in  1  from address generator; high when its address equals the terminal value for the current direction (all-ones up, zero down).
REQ-007 adres  in  Adr_size  current address from the address generator.
REQ-008 adr_en  out  1  address generator enable (one step per cycle high).
REQ-009 adr_up_down  out  1  direction: 1 = up, 0 = down.
REQ-010 adr_pr_rst  out  1  preset pulse: generator loads 0 when adr_up_down=1, else all-ones.
REQ-011 mem_re  out  1  memory read strobe; mem_rdata valid the following cycle.
REQ-012 mem_we  out  1  memory write strobe at adres.
REQ-013 mem_wdata  out  Data_size  write data: all-zeros (w0) or all-ones (w1).
REQ-014 mem_rdata  in  Data_size  read data.
REQ-015 busy, done, fail  out  1 each  running / finished (level) / sticky mismatch flag.
REQ-016 fail_adr  out  Adr_size; fail_elem  out  3  address and element index of first mismatch.

Function
REQ-017 Algorithm is March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-018 FSM states: IDLE, PRESET, READ, CHECK, WRITE, DONE; element index register 0..5.
REQ-019 IDLE/DONE with start=1 -> PRESET next cycle, element=0, fail/fail_adr/fail_elem cleared, done=0.
REQ-020 PRESET: adr_pr_rst=1 for exactly one cycle with adr_up_down per REQ-017; next state READ, or WRITE for M0.
REQ-021 READ: mem_re=1 one cycle -> CHECK.
REQ-022 CHECK: compare mem_rdata to expected (r0 = all-zeros, r1 = all-ones); -> WRITE for M1-M4; for M5 this is the address's last op.
REQ-023 WRITE: mem_we=1, mem_wdata per element; always the address's last op in M0-M4.
REQ-024 Last op of an address with c_out=0: adr_en=1 in that cycle; next state READ (or WRITE for M0).
REQ-025 Last op with c_out=1: adr_en=0; element<5 -> element+1, PRESET; element=5 -> DONE.
REQ-026 adr_en, mem_re, mem_we, adr_pr_rst are mutually exclusive except adr_en with mem_we in the same last-op cycle; never asserted in IDLE or DONE.
REQ-027 adr_up_down is held stable for a whole element, including its PRESET cycle.
REQ-028 Mismatch in CHECK: fail=1 next cycle; fail_adr=adres and fail_elem=element only if fail was 0; later mismatches do not overwrite.
REQ-029 Run does not abort on fail; all six elements complete.
REQ-030 Latency with N=2^Adr_size: 6 PRESET cycles + N*(1+3*4+2) op cycles; N=16 gives 246 cycles from first PRESET to DONE entry.
REQ-031 busy=1 in PRESET/READ/CHECK/WRITE; done=1 in DONE, held until restart or rst.
REQ-032 start while busy is ignored.

Reset
REQ-033 rst=1 at a clock edge -> IDLE, element=0, all outputs 0 except adr_up_down=1, mem_wdata=0; overrides any state, including mid-run.
REQ-034 After a mid-run reset, no memory or address strobe is issued until a new start.

Verification
REQ-035 Fault-free 16x8 memory model + counter, start pulse -> done rises exactly 246 cycles after first PRESET, fail=0; all cells end at 0x00.
REQ-036 Bit 0 of address 5 stuck-at-1 -> fail=1, fail_adr=5, fail_elem=1; done still asserts after 246 cycles.
REQ-037 Direction check -> adr_up_down=0 throughout M3/M4 PRESETs and ops, 1 otherwise; exactly 6 adr_pr_rst pulses per run.
REQ-038 rst asserted during M2 -> IDLE next cycle, busy=0, no strobes for 10 idle cycles; new start runs a full clean pass.
REQ-039 start pulsed during M1 -> no effect; start in DONE -> fail cleared, new 246-cycle run.
REQ-040 Two faults (addr 3 in M1, addr 9 in M4) -> fail_adr=3, fail_elem=1 retained.
